// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the enum.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering bytes for the UART transmitter.
// DEPTH must be a power of 2 so the pointers wrap on their own.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by level_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with input FIFO and per-frame bit period.
// Defining UART_TX_PARITY_EN inserts an even parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [DIV_W-1:0]              div,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  uart_tx_state_t           state_q, state_d;
  logic [DIV_W-1:0]         cnt_q, cnt_d;
  logic [DIV_W-1:0]         period_q, period_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic                     ser_q, ser_d;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  logic                     fifo_pop, fifo_full, fifo_empty;
  logic [7:0]               fifo_rdata;
  logic [DIV_W-1:0]         div_clamped;
  logic                     bit_end, start_frame;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign div_clamped = (div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : div;
  assign bit_end     = (cnt_q == period_q - DIV_W'(1));

  // ser_d reflects the current state; the output flop delays the line by one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ser_d       = 1'b1;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        ser_d = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        ser_d = shift_q[0];
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        ser_d = parity_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        ser_d = 1'b1;
        if (bit_end) begin
          if (!fifo_empty) start_frame = 1'b1;
          else             state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The period is captured only here, so it stays fixed for the whole frame.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      period_d = div_clamped;
      cnt_d    = '0;
      state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= DIV_W'(UART_MIN_DIV);
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ser_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ser_q     <= ser_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign ser_tx   = ser_q;
  assign tx_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames plus multi-cycle sequences.
// Follows UART_TX_PARITY_EN to expect 8E1 frames when it is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] div      = 16'd4;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data  = 8'h00;
  logic        tx_ready;
  logic        ser_tx;
  logic        busy;
  logic [2:0]  fifo_level;

  int testsRun  = 0;
  int failCount = 0;

  uart_tx dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .div        (div),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] divVal;
    int          period;
    logic [9:0]  frame;
    logic        par;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

`ifdef UART_TX_PARITY_EN
  function automatic logic [10:0] wireFrame(input logic [9:0] f, input logic p);
    return {f[9], p, f[8:0]};
  endfunction
`else
  function automatic logic [10:0] wireFrame(input logic [9:0] f, input logic p);
    return {p & 1'b0, f};
  endfunction
`endif

  // Waits for the start bit, then compares ser_tx on every cycle of the frame.
  task automatic checkFrame(input string name, input logic [10:0] expFrame,
                            input int period, input int expGap);
    int gap      = 0;
    int bad      = 0;
    int firstBad = -1;
    int limit    = period * NB * 4 + 64;
    while (ser_tx !== 1'b0 && gap < limit) begin
      tick();
      gap++;
    end
    checkOutput({name, " start seen"}, 32'(ser_tx === 1'b0), 32'd1);
    if (ser_tx !== 1'b0) return;
    if (expGap >= 0) checkOutput({name, " gap"}, 32'(gap), 32'(expGap));
    for (int c = 0; c < NB * period; c++) begin
      if (ser_tx !== expFrame[c / period]) begin
        bad++;
        if (firstBad < 0) firstBad = c;
      end
      tick();
    end
    if (bad != 0) $display("[TB] %s first bad cycle %0d", name, firstBad);
    checkOutput({name, " frame bad cycles"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] fifoFrames [6];
    logic       fifoPar    [6];
    bit         acc;
    bit         sawFull;
    int         w;
    int         noisy;

    vecs[0] = '{8'h55, 16'd4, 4, 10'h2AA, 1'b0};
    vecs[1] = '{8'hA3, 16'd5, 5, 10'h346, 1'b0};
    vecs[2] = '{8'h00, 16'd2, 2, 10'h200, 1'b0};
    vecs[3] = '{8'hFF, 16'd3, 3, 10'h3FE, 1'b0};
    vecs[4] = '{8'h3C, 16'd0, 2, 10'h278, 1'b0};
    vecs[5] = '{8'h81, 16'd1, 2, 10'h302, 1'b0};
    vecs[6] = '{8'h07, 16'd4, 4, 10'h20E, 1'b1};
    vecs[7] = '{8'h03, 16'd4, 4, 10'h206, 1'b0};

    fifoFrames = '{10'h202, 10'h204, 10'h206, 10'h208, 10'h20A, 10'h20C};
    fifoPar    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) tick();
    checkOutput("rst ser_tx", 32'(ser_tx), 32'd1);
    checkOutput("rst tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst fifo_level", 32'(fifo_level), 32'd0);
    wb_rst_i = 1'b0;
    tick();

    // Single byte at 600 cycles per bit, with push/start latency
    div = 16'd600;
    applyStimulus(8'h55);
    checkOutput("single level", 32'(fifo_level), 32'd1);
    checkOutput("single busy", 32'(busy), 32'd1);
    checkFrame("single 0x55", wireFrame(10'h2AA, 1'b0), 600, 2);
    checkOutput("single busy after", 32'(busy), 32'd0);

    // Table of bytes and divisors, including clamped divisors 0 and 1
    foreach (vecs[i]) begin
      div = vecs[i].divVal;
      applyStimulus(vecs[i].data);
      checkFrame($sformatf("vec%0d 0x%02h", i, vecs[i].data),
                 wireFrame(vecs[i].frame, vecs[i].par), vecs[i].period, 2);
    end

    // Back-to-back "H", "i", LF: no idle cycles between frames
    div = 16'd600;
    fork
      begin
        tx_valid = 1'b1;
        tx_data  = 8'h48; tick();
        tx_data  = 8'h69; tick();
        tx_data  = 8'h0A; tick();
        tx_valid = 1'b0;
      end
      begin
        checkFrame("b2b H", wireFrame(10'h290, 1'b0), 600, 3);
        checkFrame("b2b i", wireFrame(10'h2D2, 1'b0), 600, 0);
        checkFrame("b2b LF", wireFrame(10'h214, 1'b0), 600, 0);
      end
    join
    checkOutput("b2b busy after", 32'(busy), 32'd0);

    // FIFO full: hold tx_valid through bytes 1..6
    div     = 16'd10;
    sawFull = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          tx_data  = 8'(i);
          tx_valid = 1'b1;
          acc      = 1'b0;
          w        = 0;
          while (!acc && w < 500) begin
            acc = tx_ready;
            if (!tx_ready && fifo_level == 3'd4) sawFull = 1'b1;
            tick();
            w++;
          end
        end
        tx_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++)
          checkFrame($sformatf("fifo byte%0d", i + 1),
                     wireFrame(fifoFrames[i], fifoPar[i]), 10, (i == 0) ? 3 : 0);
      end
    join
    checkOutput("fifo full seen", 32'(sawFull), 32'd1);

    // Divisor change mid-frame affects only the next frame
    div = 16'd8;
    applyStimulus(8'hA3);
    fork
      checkFrame("div8 0xA3", wireFrame(10'h346, 1'b0), 8, 2);
      begin
        repeat (30) tick();
        div = 16'd16;
      end
    join
    applyStimulus(8'h3C);
    checkFrame("div16 0x3C", wireFrame(10'h278, 1'b0), 16, 2);

    // Reset during data bit 3 of 0xF0 with two bytes queued
    div = 16'd8;
    applyStimulus(8'hF0);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (34) tick();
    checkOutput("midrst pre ser_tx", 32'(ser_tx), 32'd0);
    checkOutput("midrst pre level", 32'(fifo_level), 32'd2);
    wb_rst_i = 1'b1;
    #1;
    checkOutput("midrst ser_tx", 32'(ser_tx), 32'd1);
    checkOutput("midrst level", 32'(fifo_level), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    tick();
    tick();
    wb_rst_i = 1'b0;
    noisy = 0;
    for (int c = 0; c < 200; c++) begin
      if (ser_tx !== 1'b1 || busy !== 1'b0) noisy++;
      tick();
    end
    checkOutput("midrst quiet after", 32'(noisy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
